// File: rtl/pompa_hakemi.sv
// Round-robin scheduler that shares two fuel pumps among four lanes. It times each
// service by its fuel type and keeps a saturating count of completed services.
module pompa_hakemi #(
  parameter int SURE1 = 3,
  parameter int SURE2 = 5,
  parameter int SURE3 = 8
) (
  input  logic       saat,
  input  logic       reset,
  input  logic [3:0] talep,
  input  logic [7:0] islem_tipi,
  output logic [3:0] kabul,
  output logic [1:0] pompa_mesgul,
  output logic [3:0] pompa_hat,
  output logic [1:0] bitti,
  output logic [7:0] hizmet_sayisi
);

  // Handshake: talep[i] behaves as a valid that the lane holds until it sees
  // kabul[i] (the one-cycle ready/accept pulse). A lane is never re-granted
  // while a busy pump still holds it.

  typedef enum logic {BOS = 1'b0, MESGUL = 1'b1} pompa_durum_t;

  pompa_durum_t durum_q [2];
  pompa_durum_t durum_d [2];
  logic [3:0]   kalan_q [2];
  logic [3:0]   kalan_d [2];
  logic [1:0]   oncelik_q, oncelik_d;
  logic [3:0]   kabul_d;
  logic [3:0]   hat_d;
  logic [1:0]   bitti_d;
  logic [7:0]   sayi_d;
  logic [8:0]   toplam;

  logic [3:0]   uygun;
  logic         tutulan;
  logic         bos_var;
  logic         hedef;
  logic         secili_var;
  logic [1:0]   secili;
  logic [1:0]   aday;

  // The counter value loaded at grant is the service length minus one, so the
  // pump stays busy for exactly SURE cycles.
  function automatic logic [3:0] sure_eksi1(input logic [1:0] tip);
    case (tip)
      2'd1:    sure_eksi1 = 4'(SURE1 - 1);
      2'd2:    sure_eksi1 = 4'(SURE2 - 1);
      2'd3:    sure_eksi1 = 4'(SURE3 - 1);
      default: sure_eksi1 = 4'd0;
    endcase
  endfunction

  // The pump state register is exposed directly as the busy output.
  assign pompa_mesgul = {durum_q[1] == MESGUL, durum_q[0] == MESGUL};

  always_comb begin
    uygun   = '0;
    tutulan = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tutulan = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (durum_q[p] == MESGUL && pompa_hat[2*p +: 2] == 2'(i)) tutulan = 1'b1;
      end
      uygun[i] = talep[i] && (islem_tipi[2*i +: 2] != 2'd0) && !kabul[i] && !tutulan;
    end
  end

  always_comb begin
    durum_d    = durum_q;
    kalan_d    = kalan_q;
    hat_d      = pompa_hat;
    oncelik_d  = oncelik_q;
    kabul_d    = '0;
    bitti_d    = '0;
    secili_var = 1'b0;
    secili     = 2'd0;
    aday       = 2'd0;
    bos_var    = (durum_q[0] == BOS) || (durum_q[1] == BOS);
    hedef      = (durum_q[0] == BOS) ? 1'b0 : 1'b1;

    for (int p = 0; p < 2; p++) begin
      if (durum_q[p] == MESGUL) begin
        if (kalan_q[p] == 4'd0) begin
          durum_d[p] = BOS;
          bitti_d[p] = 1'b1;
        end else begin
          kalan_d[p] = kalan_q[p] - 4'd1;
        end
      end
    end

    for (int k = 0; k < 4; k++) begin
      aday = oncelik_q + 2'(k);
      if (!secili_var && uygun[aday]) begin
        secili_var = 1'b1;
        secili     = aday;
      end
    end

    // The target pump is chosen from the pre-edge state, so a pump finishing
    // on this edge is only available from the next edge on.
    if (bos_var && secili_var) begin
      durum_d[hedef]              = MESGUL;
      kalan_d[hedef]              = sure_eksi1(islem_tipi[{secili, 1'b0} +: 2]);
      hat_d[{hedef, 1'b0} +: 2]   = secili;
      kabul_d[secili]             = 1'b1;
      oncelik_d                   = secili + 2'd1;
    end

    toplam = {1'b0, hizmet_sayisi} + 9'(bitti_d[0]) + 9'(bitti_d[1]);
    sayi_d = (toplam > 9'd255) ? 8'hFF : toplam[7:0];
  end

  always_ff @(posedge saat) begin
    if (!reset) begin
      durum_q[0]    <= BOS;
      durum_q[1]    <= BOS;
      kalan_q[0]    <= 4'd0;
      kalan_q[1]    <= 4'd0;
      oncelik_q     <= 2'd0;
      kabul         <= '0;
      pompa_hat     <= '0;
      bitti         <= '0;
      hizmet_sayisi <= '0;
    end else begin
      durum_q[0]    <= durum_d[0];
      durum_q[1]    <= durum_d[1];
      kalan_q[0]    <= kalan_d[0];
      kalan_q[1]    <= kalan_d[1];
      oncelik_q     <= oncelik_d;
      kabul         <= kabul_d;
      pompa_hat     <= hat_d;
      bitti         <= bitti_d;
      hizmet_sayisi <= sayi_d;
    end
  end

endmodule

// File: tb/tb_pompa_hakemi.sv
// Bench for pompa_hakemi: a table of per-edge vectors followed by hand-written
// sequences for round-robin order, type handling, saturation and reset abort.
module tb_pompa_hakemi;

  logic       saat;
  logic       reset;
  logic [3:0] talep;
  logic [7:0] islem_tipi;
  logic [3:0] kabul;
  logic [1:0] pompa_mesgul;
  logic [3:0] pompa_hat;
  logic [1:0] bitti;
  logic [7:0] hizmet_sayisi;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  pompa_hakemi dut (
    .saat          (saat),
    .reset         (reset),
    .talep         (talep),
    .islem_tipi    (islem_tipi),
    .kabul         (kabul),
    .pompa_mesgul  (pompa_mesgul),
    .pompa_hat     (pompa_hat),
    .bitti         (bitti),
    .hizmet_sayisi (hizmet_sayisi)
  );

  // clock / reset
  initial begin
    saat = 1'b0;
    forever #5 saat = ~saat;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic       rst;
    logic [3:0] talep;
    logic [7:0] tipi;
    logic [3:0] e_kabul;
    logic [1:0] e_mesgul;
    logic [3:0] e_hat;
    logic [1:0] e_bitti;
    logic [7:0] e_sayi;
  } vec_t;

  vec_t vec [17];

  // driver tasks
  task automatic step();
    @(posedge saat);
    @(negedge saat);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    talep      = 4'b0000;
    islem_tipi = 8'h00;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic serve_one(output logic ok);
    int n;
    ok         = 1'b1;
    talep      = 4'b0001;
    islem_tipi = 8'h01;
    n = 0;
    while (!kabul[0] && n < 6) begin
      step();
      n++;
    end
    talep = 4'b0000;
    if (!kabul[0]) begin
      chk("serve_grant_timeout", 32'd0, 32'd1);
      ok = 1'b0;
    end else begin
      n = 0;
      while (!bitti[0] && n < 12) begin
        step();
        n++;
      end
      if (!bitti[0]) begin
        chk("serve_done_timeout", 32'd0, 32'd1);
        ok = 1'b0;
      end
    end
  endtask

  initial begin
    logic       ok;
    logic [2:0] got;
    logic [2:0] want;
    int         busy;
    int         seen_bitti;
    int         seen_other;

    reset      = 1'b0;
    talep      = 4'b0000;
    islem_tipi = 8'h00;

    vec[0]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 2'b00, 4'b0000, 2'b00, 8'd0};
    vec[1]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 2'b00, 4'b0000, 2'b00, 8'd0};
    vec[2]  = '{1'b1, 4'b0000, 8'h00, 4'b0000, 2'b00, 4'b0000, 2'b00, 8'd0};
    vec[3]  = '{1'b1, 4'b0100, 8'h20, 4'b0100, 2'b01, 4'b0010, 2'b00, 8'd0};
    vec[4]  = '{1'b1, 4'b0000, 8'h20, 4'b0000, 2'b01, 4'b0010, 2'b00, 8'd0};
    vec[5]  = '{1'b1, 4'b0000, 8'h20, 4'b0000, 2'b01, 4'b0010, 2'b00, 8'd0};
    vec[6]  = '{1'b1, 4'b0000, 8'h20, 4'b0000, 2'b01, 4'b0010, 2'b00, 8'd0};
    vec[7]  = '{1'b1, 4'b0000, 8'h20, 4'b0000, 2'b01, 4'b0010, 2'b00, 8'd0};
    vec[8]  = '{1'b1, 4'b0000, 8'h00, 4'b0000, 2'b00, 4'b0010, 2'b01, 8'd1};
    vec[9]  = '{1'b1, 4'b0000, 8'h00, 4'b0000, 2'b00, 4'b0010, 2'b00, 8'd1};
    vec[10] = '{1'b1, 4'b1111, 8'h55, 4'b1000, 2'b01, 4'b0011, 2'b00, 8'd1};
    vec[11] = '{1'b1, 4'b0111, 8'h55, 4'b0001, 2'b11, 4'b0011, 2'b00, 8'd1};
    vec[12] = '{1'b1, 4'b0110, 8'h55, 4'b0000, 2'b11, 4'b0011, 2'b00, 8'd1};
    vec[13] = '{1'b1, 4'b0110, 8'h55, 4'b0000, 2'b10, 4'b0011, 2'b01, 8'd2};
    vec[14] = '{1'b1, 4'b0110, 8'h55, 4'b0010, 2'b01, 4'b0001, 2'b10, 8'd3};
    vec[15] = '{1'b1, 4'b0100, 8'h55, 4'b0100, 2'b11, 4'b1001, 2'b00, 8'd3};
    vec[16] = '{1'b1, 4'b0000, 8'h55, 4'b0000, 2'b11, 4'b1001, 2'b00, 8'd3};

    for (int i = 0; i < 17; i++) begin
      reset      = vec[i].rst;
      talep      = vec[i].talep;
      islem_tipi = vec[i].tipi;
      step();
      chk($sformatf("v%0d_kabul", i),  32'(kabul),         32'(vec[i].e_kabul));
      chk($sformatf("v%0d_mesgul", i), 32'(pompa_mesgul),  32'(vec[i].e_mesgul));
      chk($sformatf("v%0d_hat", i),    32'(pompa_hat),     32'(vec[i].e_hat));
      chk($sformatf("v%0d_bitti", i),  32'(bitti),         32'(vec[i].e_bitti));
      chk($sformatf("v%0d_sayi", i),   32'(hizmet_sayisi), 32'(vec[i].e_sayi));
    end

    // round-robin from pointer 0 with both pumps contended; scoreboard holds {pump, lane}
    do_reset();
    exp_q      = {3'b0_00, 3'b1_01, 3'b0_10, 3'b1_11};
    talep      = 4'b1111;
    islem_tipi = 8'h55;
    for (int n = 0; n < 40 && hizmet_sayisi != 8'd4; n++) begin
      step();
      if (kabul != 4'b0000) begin
        chk("rr_onehot", 32'($countones(kabul)), 32'd1);
        got = 3'b000;
        for (int l = 0; l < 4; l++) begin
          if (kabul[l]) begin
            got[1:0] = 2'(l);
            got[2]   = (pompa_mesgul[1] && pompa_hat[3:2] == 2'(l)) ? 1'b1 : 1'b0;
          end
        end
        if (exp_q.size() == 0) begin
          chk("rr_extra_grant", 32'(got), 32'h7);
        end else begin
          want = exp_q.pop_front();
          chk("rr_pump_lane", 32'(got), 32'(want));
        end
        talep = talep & ~kabul;
      end
    end
    chk("rr_count", 32'(hizmet_sayisi), 32'd4);
    chk("rr_queue_left", 32'(exp_q.size()), 32'd0);

    // type 0 never granted; type change mid-service does not shorten it
    do_reset();
    talep      = 4'b0011;
    islem_tipi = 8'h03;
    step();
    chk("t0_grant_lane0", 32'(kabul), 32'b0001);
    talep      = 4'b0010;
    islem_tipi = 8'h01;
    busy       = (pompa_mesgul[0]) ? 1 : 0;
    seen_other = 0;
    seen_bitti = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (pompa_mesgul[0]) busy++;
      if (kabul[1] || pompa_mesgul[1]) seen_other++;
      if (bitti[0]) seen_bitti++;
    end
    chk("t3_busy_len", 32'(busy), 32'd8);
    chk("t0_lane1_never", 32'(seen_other), 32'd0);
    chk("t3_bitti_once", 32'(seen_bitti), 32'd1);
    chk("t3_count", 32'(hizmet_sayisi), 32'd1);

    // preload 254 services, then double finish and saturation
    do_reset();
    ok = 1'b1;
    for (int n = 0; n < 254 && ok; n++) begin
      serve_one(ok);
    end
    step();
    chk("sat_preload", 32'(hizmet_sayisi), 32'd254);
    talep      = 4'b0001;
    islem_tipi = 8'h06;
    step();
    chk("dbl_grant_lane0", 32'(kabul), 32'b0001);
    talep = 4'b0000;
    step();
    talep = 4'b0010;
    step();
    chk("dbl_grant_lane1", 32'(kabul), 32'b0010);
    chk("dbl_both_busy", 32'(pompa_mesgul), 32'b11);
    talep = 4'b0000;
    step();
    step();
    chk("dbl_before_bitti", 32'(bitti), 32'b00);
    step();
    chk("dbl_bitti", 32'(bitti), 32'b11);
    chk("dbl_sat_255", 32'(hizmet_sayisi), 32'd255);
    serve_one(ok);
    step();
    chk("sat_hold_255", 32'(hizmet_sayisi), 32'd255);

    // reset during the third busy cycle of a type 3 service
    do_reset();
    talep      = 4'b0001;
    islem_tipi = 8'h03;
    step();
    chk("rst_mid_busy1", 32'(pompa_mesgul), 32'b01);
    talep = 4'b0000;
    step();
    step();
    chk("rst_mid_busy3", 32'(pompa_mesgul), 32'b01);
    reset = 1'b0;
    step();
    chk("rst_mid_outputs", 32'({kabul, pompa_mesgul, pompa_hat, bitti, hizmet_sayisi}), 32'd0);
    reset      = 1'b1;
    seen_bitti = 0;
    busy       = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (bitti != 2'b00) seen_bitti++;
      if (pompa_mesgul != 2'b00) busy++;
    end
    chk("rst_mid_no_bitti", 32'(seen_bitti), 32'd0);
    chk("rst_mid_no_busy", 32'(busy), 32'd0);
    chk("rst_mid_count", 32'(hizmet_sayisi), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pompa_hakemi.md
# pompa_hakemi

Round-robin scheduler that shares the station's two fuel pumps among four vehicle lanes. Each lane raises a request tagged with a 2-bit service type. The block grants an idle pump, times the service by type, and signals completion. It also keeps a saturating count of completed services, which feeds the station's daily accounting and break-even logic.

## Interface
Parameters:
- SURE1, default 3: service length in cycles for type 1 (benzin); legal range 1..15
- SURE2, default 5: service length in cycles for type 2 (dizel); legal range 1..15
- SURE3, default 8: service length in cycles for type 3 (LPG); legal range 1..15

Ports:
- saat  input  1: single clock, all state updates on its rising edge
- reset  input  1: synchronous, active-low; sampled on the rising edge of saat
- talep  input  4: per-lane request level; bit i belongs to lane i
- islem_tipi  input  8: service type per lane; bits [2i+1:2i] belong to lane i; 0 means no service
- kabul  output  4: one-cycle grant pulse per lane
- pompa_mesgul  output  2: pump p is serving a vehicle
- pompa_hat  output  4: lane served by each pump; bits [2p+1:2p] belong to pump p
- bitti  output  2: one-cycle completion pulse per pump
- hizmet_sayisi  output  8: completed services, saturating

## Operation
- Eligible lane i: talep[i]=1, islem_tipi lane field ≠0, kabul[i]=0 in the current cycle, and lane i not currently held by a busy pump.
  - A lane with type 0 is ignored and never granted, even while talep=1.
- Pump state per pump: BOS (idle) → MESGUL on grant; MESGUL → BOS when its down-counter kalan (4 bits) is 0.
- Grants: at most one per edge.
  - Target pump is the lowest-index pump in BOS; pump 0 wins when both are idle.
  - No grant is made if no pump is in BOS or no lane is eligible.
- Round-robin order: 2-bit pointer oncelik, reset 0.
  - The search order is oncelik, oncelik+1, … mod 4; the first eligible lane wins.
  - After granting lane L, oncelik becomes (L+1) mod 4, so lane 3 wraps to lane 0.
  - The pointer is unchanged when no grant is made.
- On a grant to lane L at pump p:
  - state(p)=MESGUL, kalan(p)=SURE(type)−1, pompa_hat field p = L, kabul[L]=1 for one cycle.
  - The type is latched at the grant; later changes to islem_tipi do not affect a service in progress.
- While MESGUL with kalan>0, kalan decrements by 1 each edge.
- While MESGUL with kalan=0, at the next edge:
  - state(p)=BOS and bitti[p]=1 for one cycle.
  - hizmet_sayisi increments.
  - pompa_hat field p holds its last value.
- Counter arithmetic:
  - Two pumps finishing on the same edge add 2.
  - The count saturates at 255 and never wraps; a value of 254 plus a double finish gives 255.
- Requester protocol: a lane holds talep until it sees kabul, then drops talep.
  - A lane that keeps talep high after kabul is re-queued only once its service ends.

## Timing
- Reset (reset=0 at an edge) sets every output to 0: kabul, pompa_mesgul, pompa_hat, bitti, hizmet_sayisi. It also sets oncelik=0 and kalan=0.
- Reset mid-service aborts the service: no bitti pulse, no count increment.
- All outputs are registered; there is no combinational path from input to output.
- Grant latency: talep is sampled at edge E, and kabul plus pompa_mesgul are high in the cycle after E.
- Busy length: pompa_mesgul stays high for exactly SURE(type) cycles. bitti is high in the first cycle after pompa_mesgul falls, and hizmet_sayisi updates in that same cycle.
- Pump reuse: a pump that returns to BOS at edge F cannot be re-granted at F; its earliest next grant is edge F+1.
- Simultaneous events: a grant to one pump and completion of the other on the same edge are both performed.

## Test plan
- Reset: hold reset=0 for 2 cycles with talep=4'b1111 → all outputs 0 and no kabul during reset.
- Single request: lane 2 with type 2 → kabul[2] pulses once; pompa_mesgul[0] is high for 5 cycles with pompa_hat[1:0]=2; bitti[0] pulses; hizmet_sayisi=1.
- Round-robin with both pumps busy: all lanes request type 1 and hold talep until kabul.
  - Expected grant order is lanes 0, 1, 2, 3: lane 0 to pump 0 and lane 1 to pump 1 on consecutive cycles.
  - Lanes 2 and 3 wait for pumps to free; the pointer wraps to 0.
  - Final hizmet_sayisi=4.
- Type 0 and a mid-service type change: lane 1 with type 0 is never granted. Lane 0 granted with type 3 then switched to type 1 → still busy 8 cycles.
- Double finish and saturation: preload the count to 254 using 254 type 1 services, then complete 2 services on the same edge → hizmet_sayisi=255, then one more service → still 255.
- Reset mid-service: assert reset at the 3rd busy cycle of a type 3 service → pompa_mesgul=0, no bitti, hizmet_sayisi unchanged at 0.
